// File: rtl/sync_ram_pkg.sv
// Shared definitions for the synchronous RAM family.
// Holds the read-during-write policy codes and a lane-count helper.
package sync_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic int num_lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/sync_ram_out_pipe.sv
// Optional output register stage for the data and valid signals.
// STAGES=0 is a pass-through. STAGES=1 adds one cycle of read latency.
module sync_ram_out_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    if (STAGES != 0 && STAGES != 1) begin : g_bad_stages
        $error("sync_ram_out_pipe: STAGES must be 0 or 1");
    end

    if (STAGES == 0) begin : g_bypass
        // In bypass mode the clock and reset are deliberately left unconnected.
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst};
        assign out_data  = in_data;
        assign out_valid = in_valid;
    end else begin : g_stage
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        // Data loads only with a valid entry, so rdata holds while the stage is empty.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) data_q <= in_data;
            end
        end

        assign out_data  = data_q;
        assign out_valid = valid_q;
    end

endmodule

// File: rtl/sync_ram_dp_pipe.sv
// Simple-dual-port synchronous RAM with per-lane write enables, a read-valid
// strobe, a read latency of 1 or 2 cycles and a selectable read-during-write policy.
module sync_ram_dp_pipe
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = RDW_READ_FIRST
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          we,
    input  logic [num_lanes(DATA_WIDTH, LANE_WIDTH)-1:0]  wbe,
    input  logic [ADDR_WIDTH-1:0]                         waddr,
    input  logic [DATA_WIDTH-1:0]                         wdata,
    input  logic                                          re,
    input  logic [ADDR_WIDTH-1:0]                         raddr,
    output logic [DATA_WIDTH-1:0]                         rdata,
    output logic                                          rvalid
);

    localparam int NUM_LANES = num_lanes(DATA_WIDTH, LANE_WIDTH);

    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lanes
        $error("sync_ram_dp_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sync_ram_dp_pipe: RD_LATENCY must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
        $error("sync_ram_dp_pipe: DEPTH must be within 1..2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  w_ok;
    logic                  r_ok;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    assign w_ok = we && (32'(waddr) < DEPTH);
    assign r_ok = 32'(raddr) < DEPTH;

    // NOTE: the array has no reset so it maps onto block RAM; rst only suppresses writes.
    always_ff @(posedge clk) begin
        if (!rst && w_ok) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wbe[i]) mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_word = r_ok ? mem[raddr] : '0;
        if (RDW_MODE == RDW_WRITE_FIRST && r_ok && w_ok && waddr == raddr) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wbe[i]) rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= re;
            if (re) rd_data_q <= rd_word;
        end
    end

    sync_ram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY - 1)
    ) u_out_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_data   (rd_data_q),
        .in_valid  (rd_valid_q),
        .out_data  (rdata),
        .out_valid (rvalid)
    );

endmodule

// File: tb/tb_sync_ram_dp_pipe.sv
// Directed bench for sync_ram_dp_pipe: dut_a is latency 1 / read-first / full depth,
// dut_b is latency 2 / write-first / DEPTH 200. Both share one stimulus bus.
module tb_sync_ram_dp_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  wbe = 2'b00;
    logic [7:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic        re = 1'b0;
    logic [7:0]  raddr = '0;
    logic [15:0] a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_ram_dp_pipe #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .LANE_WIDTH(8),
        .DEPTH(256), .RD_LATENCY(1), .RDW_MODE(0)
    ) dut_a (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(a_rdata), .rvalid(a_rvalid)
    );

    sync_ram_dp_pipe #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .LANE_WIDTH(8),
        .DEPTH(200), .RD_LATENCY(2), .RDW_MODE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(b_rdata), .rvalid(b_rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] be);
        we = 1'b1; waddr = addr; wdata = data; wbe = be;
        tick();
        we = 1'b0; wbe = 2'b00;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_a_rvalid: got %b expected 0", a_rvalid); end
        checks++; if (a_rdata !== 16'h0000) begin errors++; $display("FAIL reset_a_rdata: got %h expected 0000", a_rdata); end
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_b_rvalid: got %b expected 0", b_rvalid); end
        checks++; if (b_rdata !== 16'h0000) begin errors++; $display("FAIL reset_b_rdata: got %h expected 0000", b_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_lane_mask();
        do_write(8'd3, 16'h1234, 2'b11);
        do_write(8'd3, 16'h00A5, 2'b01);
        re = 1'b1; raddr = 8'd3;
        tick();
        re = 1'b0;
        checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL lane_a_rvalid: got %b expected 1", a_rvalid); end
        checks++; if (a_rdata !== 16'h12A5) begin errors++; $display("FAIL lane_a_rdata: got %h expected 12a5", a_rdata); end
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL lane_b_rvalid_early: got %b expected 0", b_rvalid); end
        tick();
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL lane_a_rvalid_drop: got %b expected 0", a_rvalid); end
        checks++; if (a_rdata !== 16'h12A5) begin errors++; $display("FAIL lane_a_rdata_hold: got %h expected 12a5", a_rdata); end
        checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL lane_b_rvalid: got %b expected 1", b_rvalid); end
        checks++; if (b_rdata !== 16'h12A5) begin errors++; $display("FAIL lane_b_rdata: got %h expected 12a5", b_rdata); end
        tick();
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL lane_b_rvalid_drop: got %b expected 0", b_rvalid); end
        checks++; if (b_rdata !== 16'h12A5) begin errors++; $display("FAIL lane_b_rdata_hold: got %h expected 12a5", b_rdata); end
    endtask

    task automatic test_back_to_back();
        logic        exp_av, exp_bv;
        logic [15:0] exp_ad, exp_bd;
        for (int i = 0; i < 8; i++) do_write(8'(i), 16'(i * 3), 2'b11);
        for (int k = 0; k < 10; k++) begin
            re = (k < 8); raddr = 8'(k);
            tick();
            exp_av = (k < 8);
            exp_ad = 16'(k * 3);
            exp_bv = (k >= 1 && k <= 8);
            exp_bd = 16'((k - 1) * 3);
            checks++; if (a_rvalid !== exp_av) begin errors++; $display("FAIL b2b_a_rvalid[%0d]: got %b expected %b", k, a_rvalid, exp_av); end
            if (exp_av) begin
                checks++; if (a_rdata !== exp_ad) begin errors++; $display("FAIL b2b_a_rdata[%0d]: got %h expected %h", k, a_rdata, exp_ad); end
            end
            checks++; if (b_rvalid !== exp_bv) begin errors++; $display("FAIL b2b_b_rvalid[%0d]: got %b expected %b", k, b_rvalid, exp_bv); end
            if (exp_bv) begin
                checks++; if (b_rdata !== exp_bd) begin errors++; $display("FAIL b2b_b_rdata[%0d]: got %h expected %h", k, b_rdata, exp_bd); end
            end
        end
        re = 1'b0;
    endtask

    task automatic test_collision();
        do_write(8'd5, 16'h0011, 2'b11);
        we = 1'b1; waddr = 8'd5; wdata = 16'h0022; wbe = 2'b11;
        re = 1'b1; raddr = 8'd5;
        tick();
        we = 1'b0; wbe = 2'b00;
        checks++; if (a_rdata !== 16'h0011) begin errors++; $display("FAIL rdw_read_first: got %h expected 0011", a_rdata); end
        tick();
        re = 1'b0;
        checks++; if (a_rdata !== 16'h0022) begin errors++; $display("FAIL rdw_read_first_next: got %h expected 0022", a_rdata); end
        checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL rdw_write_first_rvalid: got %b expected 1", b_rvalid); end
        checks++; if (b_rdata !== 16'h0022) begin errors++; $display("FAIL rdw_write_first: got %h expected 0022", b_rdata); end
        tick();
        checks++; if (b_rdata !== 16'h0022) begin errors++; $display("FAIL rdw_write_first_next: got %h expected 0022", b_rdata); end

        do_write(8'd6, 16'hBEEF, 2'b11);
        we = 1'b1; waddr = 8'd6; wdata = 16'h1234; wbe = 2'b10;
        re = 1'b1; raddr = 8'd6;
        tick();
        we = 1'b0; wbe = 2'b00;
        checks++; if (a_rdata !== 16'hBEEF) begin errors++; $display("FAIL rdw_merge_read_first: got %h expected beef", a_rdata); end
        tick();
        re = 1'b0;
        checks++; if (a_rdata !== 16'h12EF) begin errors++; $display("FAIL rdw_merge_next: got %h expected 12ef", a_rdata); end
        checks++; if (b_rdata !== 16'h12EF) begin errors++; $display("FAIL rdw_merge_write_first: got %h expected 12ef", b_rdata); end
        tick();
        checks++; if (b_rdata !== 16'h12EF) begin errors++; $display("FAIL rdw_merge_write_first_next: got %h expected 12ef", b_rdata); end
    endtask

    task automatic test_out_of_range();
        do_write(8'd50, 16'h5050, 2'b11);
        do_write(8'd250, 16'h00FF, 2'b11);
        re = 1'b1; raddr = 8'd250;
        tick();
        raddr = 8'd50;
        checks++; if (a_rdata !== 16'h00FF) begin errors++; $display("FAIL oor_a_in_range: got %h expected 00ff", a_rdata); end
        tick();
        re = 1'b0;
        checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL oor_b_rvalid: got %b expected 1", b_rvalid); end
        checks++; if (b_rdata !== 16'h0000) begin errors++; $display("FAIL oor_b_rdata: got %h expected 0000", b_rdata); end
        tick();
        checks++; if (b_rdata !== 16'h5050) begin errors++; $display("FAIL oor_b_addr50: got %h expected 5050", b_rdata); end
    endtask

    task automatic test_reset_midstream();
        re = 1'b1; raddr = 8'd2;
        tick();
        raddr = 8'd3;
        tick();
        re = 1'b0;
        checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL mid_b_rvalid_pre: got %b expected 1", b_rvalid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL mid_b_rvalid_async: got %b expected 0", b_rvalid); end
        checks++; if (b_rdata !== 16'h0000) begin errors++; $display("FAIL mid_b_rdata_async: got %h expected 0000", b_rdata); end
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mid_a_rvalid_async: got %b expected 0", a_rvalid); end
        checks++; if (a_rdata !== 16'h0000) begin errors++; $display("FAIL mid_a_rdata_async: got %h expected 0000", a_rdata); end
        we = 1'b1; waddr = 8'd7; wdata = 16'hDEAD; wbe = 2'b11;
        tick(); tick();
        we = 1'b0; wbe = 2'b00;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mid_a_no_rvalid[%0d]: got %b expected 0", k, a_rvalid); end
            checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL mid_b_no_rvalid[%0d]: got %b expected 0", k, b_rvalid); end
        end
        re = 1'b1; raddr = 8'd7;
        tick();
        re = 1'b0;
        checks++; if (a_rdata !== 16'h0015) begin errors++; $display("FAIL mid_a_write_blocked: got %h expected 0015", a_rdata); end
        tick();
        checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL mid_b_rvalid_post: got %b expected 1", b_rvalid); end
        checks++; if (b_rdata !== 16'h0015) begin errors++; $display("FAIL mid_b_write_blocked: got %h expected 0015", b_rdata); end
    endtask

    initial begin
        test_reset();
        test_lane_mask();
        test_back_to_back();
        test_collision();
        test_out_of_range();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
